// File: rtl/noc_pkg.sv
// Shared definitions for the PE-side NoC endpoint.
// Flit layout is {addr, payload} with the address in the MSBs. The default widths below
// match the endpoint's default parameters; the helper functions operate on those widths.
package noc_pkg;

  localparam int unsigned NocDataWidth = 32;
  localparam int unsigned NocAddrWidth = 2;
  localparam int unsigned NocFlitWidth = NocDataWidth + NocAddrWidth;
  localparam int unsigned StatsWidth   = 16;

  typedef logic [NocFlitWidth-1:0] flit_t;
  typedef logic [NocDataWidth-1:0] payload_t;
  typedef logic [NocAddrWidth-1:0] addr_t;

  function automatic addr_t flit_addr(input flit_t flit);
    return flit[NocFlitWidth-1 -: NocAddrWidth];
  endfunction

  function automatic payload_t flit_payload(input flit_t flit);
    return flit[NocDataWidth-1:0];
  endfunction

  function automatic flit_t make_flit(input addr_t addr, input payload_t payload);
    return {addr, payload};
  endfunction

endpackage

// File: rtl/endpoint_fifo.sv
// Synchronous FIFO used for both endpoint directions.
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/wdata_i write side;
//        pop_i read side; head_o current head entry; full_o/empty_o status.
// Push is ignored when full and pop is ignored when empty. No fall-through: a push into an
// empty FIFO becomes visible on head_o/empty_o the following cycle.
module endpoint_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);  // Depth is a power of two: natural wrap
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    count_d = count_q + CntW'(do_push) - CntW'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/noc_pe_endpoint.sv
// PE-side NoC endpoint: packs PE words into {dest, payload} flits toward the NoC and
// delivers payloads of flits addressed to MyAddr back to the PE, dropping the rest.
// Ports: i_clk, i_reset (async, active-low); i_tx_* / o_tx_ready PE transmit side;
//        o_noc_data* / i_noc_data_ready flits to the NoC; i_noc_data* / o_noc_data_ready
//        flits from the NoC; o_rx_* / i_rx_ready PE receive side; o_misroute sticky
//        wrong-address flag with i_clear_misroute synchronous clear.
// Optional: define ENDPOINT_STATS_EN to add saturating o_tx_count/o_rx_count/o_drop_count.
module noc_pe_endpoint
  import noc_pkg::*;
#(
  parameter int unsigned          DataWidth = NocDataWidth,
  parameter int unsigned          AddrWidth = NocAddrWidth,
  parameter logic [AddrWidth-1:0] MyAddr    = '0,
  parameter int unsigned          FifoDepth = 4
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic [DataWidth-1:0]           i_tx_data,
  input  logic [AddrWidth-1:0]           i_tx_dest,
  input  logic                           i_tx_valid,
  output logic                           o_tx_ready,
  output logic [DataWidth+AddrWidth-1:0] o_noc_data,
  output logic                           o_noc_data_valid,
  input  logic                           i_noc_data_ready,
  input  logic [DataWidth+AddrWidth-1:0] i_noc_data,
  input  logic                           i_noc_data_valid,
  output logic                           o_noc_data_ready,
  output logic [DataWidth-1:0]           o_rx_data,
  output logic                           o_rx_valid,
  input  logic                           i_rx_ready,
`ifdef ENDPOINT_STATS_EN
  output logic [StatsWidth-1:0]          o_tx_count,
  output logic [StatsWidth-1:0]          o_rx_count,
  output logic [StatsWidth-1:0]          o_drop_count,
`endif
  output logic                           o_misroute,
  input  logic                           i_clear_misroute
);

  localparam int unsigned FlitWidth = DataWidth + AddrWidth;

  logic tx_full, tx_empty, tx_push, tx_pop;
  logic rx_full, rx_empty, rx_accept, rx_match, rx_push, rx_drop;
  logic misroute_q, misroute_d;

  // TX path
  assign o_tx_ready       = !tx_full;
  assign o_noc_data_valid = !tx_empty;
  assign tx_push          = i_tx_valid && !tx_full;
  assign tx_pop           = !tx_empty && i_noc_data_ready;

  endpoint_fifo #(
    .Width (FlitWidth),
    .Depth (FifoDepth)
  ) u_tx_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_reset),
    .push_i  (tx_push),
    .wdata_i ({i_tx_dest, i_tx_data}),
    .pop_i   (tx_pop),
    .head_o  (o_noc_data),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  // RX path: ready depends only on occupancy, so misrouted flits are consumed as well
  assign o_noc_data_ready = !rx_full;
  assign o_rx_valid       = !rx_empty;
  assign rx_accept        = i_noc_data_valid && !rx_full;
  assign rx_match         = (i_noc_data[FlitWidth-1 -: AddrWidth] == MyAddr);
  assign rx_push          = rx_accept && rx_match;
  assign rx_drop          = rx_accept && !rx_match;

  endpoint_fifo #(
    .Width (DataWidth),
    .Depth (FifoDepth)
  ) u_rx_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_reset),
    .push_i  (rx_push),
    .wdata_i (i_noc_data[DataWidth-1:0]),
    .pop_i   (i_rx_ready),
    .head_o  (o_rx_data),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  // Set wins over clear in the same cycle
  always_comb begin
    misroute_d = misroute_q;
    if (i_clear_misroute) misroute_d = 1'b0;
    if (rx_drop)          misroute_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) misroute_q <= 1'b0;
    else          misroute_q <= misroute_d;
  end

  assign o_misroute = misroute_q;

`ifdef ENDPOINT_STATS_EN
  logic [StatsWidth-1:0] tx_count_q, tx_count_d;
  logic [StatsWidth-1:0] rx_count_q, rx_count_d;
  logic [StatsWidth-1:0] drop_count_q, drop_count_d;

  // Saturating counters
  always_comb begin
    tx_count_d   = tx_count_q;
    rx_count_d   = rx_count_q;
    drop_count_d = drop_count_q;
    if (tx_pop  && tx_count_q   != '1) tx_count_d   = tx_count_q + StatsWidth'(1);
    if (rx_push && rx_count_q   != '1) rx_count_d   = rx_count_q + StatsWidth'(1);
    if (rx_drop && drop_count_q != '1) drop_count_d = drop_count_q + StatsWidth'(1);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      tx_count_q   <= '0;
      rx_count_q   <= '0;
      drop_count_q <= '0;
    end else begin
      tx_count_q   <= tx_count_d;
      rx_count_q   <= rx_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign o_tx_count   = tx_count_q;
  assign o_rx_count   = rx_count_q;
  assign o_drop_count = drop_count_q;
`endif

endmodule

// File: doc/noc_pe_endpoint.md
# noc_pe_endpoint

PE-side network endpoint that attaches one processing element to an HNoC PE port. It packs PE transmit words with a destination address into flits and buffers them toward the NoC. On the receive side it buffers flits arriving from the NoC, checks each flit's address against its own ID and strips the address before handing the payload to the PE. One instance sits between each PE and its `i_pe_data*`/`o_pe_data*` port pair.

## Interface
- `DataWidth`, 32, payload width in bits.
- `AddrWidth`, 2, destination-address width in bits.
- `MyAddr`, 0, this endpoint's PE index; width `AddrWidth`.
- `FifoDepth`, 4, entries per FIFO; power of two, ≥2.

Ports:
- `i_clk` in 1: the single clock for the block.
- `i_reset` in 1: asynchronous, active-low reset.
- `i_tx_data` in `DataWidth`: PE payload to send.
- `i_tx_dest` in `AddrWidth`: destination PE index.
- `i_tx_valid` in 1: PE transmit request.
- `o_tx_ready` out 1: TX FIFO can accept a word.
- `o_noc_data` out `DataWidth+AddrWidth`: flit to the NoC PE input.
- `o_noc_data_valid` out 1: flit valid.
- `i_noc_data_ready` in 1: NoC accepts the flit.
- `i_noc_data` in `DataWidth+AddrWidth`: flit from the NoC PE output.
- `i_noc_data_valid` in 1: incoming flit valid.
- `o_noc_data_ready` out 1: RX FIFO can accept a flit.
- `o_rx_data` out `DataWidth`: received payload.
- `o_rx_valid` out 1: payload valid.
- `i_rx_ready` in 1: PE accepts the payload.
- `o_misroute` out 1: sticky flag; set when a flit's address ≠ `MyAddr`.
- `i_clear_misroute` in 1: synchronous clear of `o_misroute`.

## Operation
- **Flit format:** `{addr[AddrWidth-1:0], payload[DataWidth-1:0]}`, with the address in the MSBs.
- **TX path:**
  - A push occurs on `i_tx_valid && o_tx_ready` and writes `{i_tx_dest, i_tx_data}` into the TX FIFO.
  - `o_noc_data_valid` = TX FIFO not empty.
  - `o_noc_data` = head entry, held stable while valid is high and ready is low.
  - A pop occurs on `o_noc_data_valid && i_noc_data_ready`.
- **RX path:**
  - A flit is accepted on `i_noc_data_valid && o_noc_data_ready`.
  - If the flit's address = `MyAddr`, its payload is pushed into the RX FIFO.
  - Otherwise the flit is consumed and discarded, and `o_misroute` is set.
  - `o_rx_valid` = RX FIFO not empty; a pop occurs on `o_rx_valid && i_rx_ready`.
- **Ready rules:**
  - `o_tx_ready` = TX FIFO not full.
  - `o_noc_data_ready` = RX FIFO not full. This holds for misrouted flits too, so readiness never depends on data.
- **FIFO behaviour:**
  - Each FIFO has read/write pointers plus an occupancy count of width log2(`FifoDepth`)+1; pointers wrap modulo `FifoDepth`.
  - Push and pop may occur in the same cycle; on a full FIFO only the pop takes effect, because ready is low.
  - On an empty FIFO a simultaneous push still yields valid on the next cycle. There is no fall-through.
- **Self-addressed TX** (`i_tx_dest == MyAddr`) is sent into the NoC unchanged.
- **`o_misroute` priority:** set has priority over `i_clear_misroute` in the same cycle.
- **Reset:**
  - Pointers, counts, `o_misroute` and stats are cleared to 0.
  - `o_noc_data_valid` = 0, `o_rx_valid` = 0.
  - `o_tx_ready` = 1 and `o_noc_data_ready` = 1, since both FIFOs are empty.
  - Data outputs are 0.
  - Reset asserted mid-transfer discards all buffered flits; no partial state survives.

## Timing
- TX latency: a push in cycle N gives `o_noc_data_valid` = 1 in cycle N+1.
- RX latency: an accept in cycle N gives `o_rx_valid` = 1 in cycle N+1.
- Each direction sustains 1 flit/cycle when the downstream ready stays high.
- With `FifoDepth`=4 and the sink stalled, `o_tx_ready` drops in the cycle after the 4th push.
- `o_misroute` rises in the cycle after the bad flit is accepted.
- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.

## Configuration
- **`ENDPOINT_STATS_EN` defined:**
  - Adds outputs `o_tx_count`, `o_rx_count` and `o_drop_count`, each 16 bits.
  - The counters increment on NoC-side TX pop, RX FIFO push and misroute discard respectively.
  - Counters saturate at 16'hFFFF and reset to 0.
- **Undefined:** these ports and their logic are absent; all other behaviour is identical.

## Structure
- **Package `noc_pkg`:**
  - Flit width localparam (`DataWidth+AddrWidth`).
  - Functions `flit_addr()`, `flit_payload()` and `make_flit()`.
  - Stats counter width constant (16).
- **Sub-module `endpoint_fifo`:**
  - Parameterised width/depth, synchronous FIFO.
  - Outputs full, empty and head.
  - Instantiated twice: TX at width `DataWidth+AddrWidth`, RX at width `DataWidth`.

## Test plan
- **Reset:** assert `i_reset`=0 mid-traffic → next cycle both valids are 0, both readies are 1, `o_misroute`=0, counters are 0.
- **TX single flit:** `MyAddr`=1, send data 0xDEADBEEF with dest 3 → `o_noc_data`=0x3DEADBEEF one cycle later; flit pops when `i_noc_data_ready`=1.
- **TX backpressure:** hold `i_noc_data_ready`=0 and push 5 words → `o_tx_ready`=0 after the 4th push; release ready → 4 flits emerge in order on consecutive cycles.
- **RX match:** flit {1, 0x12345678} to `MyAddr`=1 → `o_rx_data`=0x12345678 next cycle; with `ENDPOINT_STATS_EN`, `o_rx_count`=1.
- **RX misroute:** flit {2, 0xA5A5A5A5} to `MyAddr`=1 → flit is consumed, `o_rx_valid` stays 0, `o_misroute`=1; assert `i_clear_misroute` → flag returns to 0.
- **Full-rate concurrency:** push and pop every cycle on both paths for 100 cycles with random ready stalls → no loss, no duplication, order preserved; RX full blocks `o_noc_data_ready`.
